mips_cpu_regfile_port_ctrl: RTL and testbench
=============================================

Name: mips_cpu_regfile_port_ctrl

Overview:
- Owns all access to the 32x32 GPR file: arbitrates several writeback sources onto its single write port, forwards in-flight write data to the CPU read ports, and runs a debug dump sequencer.
- The sequencer borrows read port 1 while the CPU is halted and streams all 32 registers out.
- Sits between the core's writeback sources, the decode/read stage, the debug/testbench interface and mips_cpu_register_file.

Parameters:
- NREQ, 3, number of write requesters (0=ALU, 1=LOAD, 2=MULDIV); legal range 2..8.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  write request valid, per requester
- req_reg  input  5*NREQ  destination register, requester i at [5i+4:5i]
- req_data  input  32*NREQ  write data, requester i at [32i+31:32i]
- req_ready  output  NREQ  grant; a transfer occurs when valid & ready
- rf_write_enable  output  1  to regfile write_enable
- rf_write_reg  output  5  to regfile write_reg
- rf_write_data  output  32  to regfile write_data
- rf_read_reg_1  output  5  to regfile read_reg_1 (muxed)
- rf_read_reg_2  output  5  to regfile read_reg_2
- rf_read_data_1  input  32  from regfile
- rf_read_data_2  input  32  from regfile
- cpu_read_reg_1  input  5  CPU read address 1
- cpu_read_reg_2  input  5  CPU read address 2
- cpu_read_data_1  output  32  forwarded read data 1
- cpu_read_data_2  output  32  forwarded read data 2
- cpu_halted  input  1  core is halted; a dump is permitted
- cpu_rd_stall  output  1  high while read port 1 is owned by the dump sequencer
- dump_start  input  1  single-cycle request to dump the registers
- dump_valid  output  1  dump beat valid
- dump_ready  input  1  consumer accepts the dump beat
- dump_idx  output  5  register index of the current beat
- dump_data  output  32  register value of the current beat
- dump_done  output  1  one-cycle pulse after beat 31 is accepted

Behaviour:
- Reset: rf_write_enable=0, rf_write_reg=0, rf_write_data=0, rr_ptr=0, dump FSM=IDLE, dump_valid=0, dump_done=0, dump_idx=0, cpu_rd_stall=0. Reset mid-dump aborts the dump with no dump_done.
- Arbitration is combinational and grants at most one requester per cycle.
  - req_ready is one-hot or zero, and is only asserted to a requester whose req_valid is high.
  - RR_EN=1: search starts at rr_ptr. After a grant to requester g, rr_ptr <= (g+1) mod NREQ. rr_ptr is unchanged when there is no grant.
  - The write stage never back-pressures, so some valid requester is always granted.
- Write stage: one registered pipeline stage.
  - On a grant, next edge: rf_write_reg/rf_write_data <= granted reg/data; rf_write_enable <= (reg != 0).
  - A write to $0 is acknowledged and dropped.
  - With no grant, rf_write_enable <= 0 and the reg/data outputs hold their values.
  - Regfile commit occurs one edge later; total accept-to-visible latency is 2 edges.
- Ordering of same-register writes from different requesters in the same cycle is the upstream issue logic's responsibility. Arbitration order is the only ordering this block guarantees.
- Forwarding: cpu_read_data_k = rf_write_data when rf_write_enable & (rf_write_reg == cpu_read_reg_k) & (cpu_read_reg_k != 0); otherwise rf_read_data_k. Reads of $0 always return 0.
- Read port 1 mux: rf_read_reg_1 = dump_idx in SCAN, otherwise cpu_read_reg_1. rf_read_reg_2 = cpu_read_reg_2 always. cpu_rd_stall = (state == SCAN).
- Dump FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on dump_start & cpu_halted; dump_idx <= 0. dump_start without cpu_halted is ignored.
  - SCAN: dump_valid=1; dump_data = rf_read_data_1 with the same forwarding rule applied to dump_idx. dump_idx/dump_data are held stable while dump_ready=0.
  - On accept with dump_idx < 31: dump_idx++. On accept at idx 31: -> DONE.
  - DONE: dump_done=1 for exactly one cycle, then -> IDLE.
  - cpu_halted falling during SCAN: -> IDLE immediately, dump_valid drops, no dump_done.
  - dump_start while not IDLE is ignored.
- Write requests are still arbitrated during a dump. A forwarded value is what a beat reports.

Decomposition:
- mips_cpu_regfile_pkg holds:
  - typedef dump_state_t {IDLE, SCAN, DONE}
  - constants REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2
  - NUM_GPR=32, ZERO_REG=5'd0
- Sub-module mips_cpu_rr_arbiter (NREQ; inputs req, ptr; output one-hot grant) is instantiated once.

Test Plan:
- Reset, then req_valid=3'b111 held for 6 cycles with regs 8/9/10 -> grants cycle 0,1,2,0,1,2; rf_write_reg sequence 8,9,10,8,9,10 one cycle after each grant.
- LOAD writes $5=0xDEADBEEF; CPU reads $5 on the next cycle -> cpu_read_data_1=0xDEADBEEF from forwarding; two cycles later it comes from the regfile.
- ALU writes $0=0x1234 -> req_ready=1, rf_write_enable stays 0; a read of $0 returns 0.
- Preload $i = i*3, cpu_halted=1, dump_start pulse, dump_ready=1 -> 32 beats with idx 0..31 and data i*3, then a single dump_done; cpu_rd_stall high for exactly 32 cycles.
- Dump with dump_ready toggling 1/0 -> idx/data stable while stalled, no beat skipped; then cpu_halted drops at idx 17 -> dump_valid=0 next cycle, FSM IDLE, no dump_done.
- RR_EN=0 with all requesters valid -> requester 0 granted every cycle; reset asserted mid-dump -> all outputs return to reset values.

Source files
------------

// File: rtl/mips_cpu_regfile_pkg.sv
// Shared types, constants and the read-forwarding rule for the GPR port controller.
package mips_cpu_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } dump_state_t;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    localparam int          NUM_GPR  = 32;
    localparam logic [4:0]  ZERO_REG = 5'd0;

    // $0 reads as zero; otherwise the in-flight write wins over the regfile copy.
    function automatic logic [31:0] fwd_read(
        input logic        we,
        input logic [4:0]  wreg,
        input logic [31:0] wdata,
        input logic [4:0]  rreg,
        input logic [31:0] rdata
    );
        if (rreg == ZERO_REG)
            return 32'd0;
        if (we && (wreg == rreg))
            return wdata;
        return rdata;
    endfunction

endpackage

// File: rtl/mips_cpu_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or after ptr wins.
module mips_cpu_rr_arbiter #(
    parameter  int NREQ = 3,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_port_ctrl.sv
// GPR port controller: write-port arbitration, read forwarding and the debug dump sequencer.
module mips_cpu_regfile_port_ctrl
    import mips_cpu_regfile_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int RR_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_reg,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rf_write_enable,
    output logic [4:0]        rf_write_reg,
    output logic [31:0]       rf_write_data,
    output logic [4:0]        rf_read_reg_1,
    output logic [4:0]        rf_read_reg_2,
    input  logic [31:0]       rf_read_data_1,
    input  logic [31:0]       rf_read_data_2,
    input  logic [4:0]        cpu_read_reg_1,
    input  logic [4:0]        cpu_read_reg_2,
    output logic [31:0]       cpu_read_data_1,
    output logic [31:0]       cpu_read_data_2,
    input  logic              cpu_halted,
    output logic              cpu_rd_stall,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_idx,
    output logic [31:0]       dump_data,
    output logic              dump_done
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, arb_ptr, gnt_idx;
    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic [4:0]      gnt_reg;
    logic [31:0]     gnt_data;

    logic            we_q;
    logic [4:0]      wreg_q;
    logic [31:0]     wdata_q;

    dump_state_t     state_q, state_d;
    logic [4:0]      idx_q, idx_d;

    // Fixed priority is the rotating arbiter pinned at requester 0.
    assign arb_ptr = (RR_EN != 0) ? rr_ptr_q : '0;

    mips_cpu_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign gnt_any   = |grant;

    always_comb begin
        gnt_idx  = '0;
        gnt_reg  = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = PW'(i);
                gnt_reg  = req_reg[5*i +: 5];
                gnt_data = req_data[32*i +: 32];
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_any)
            rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= gnt_any && (gnt_reg != ZERO_REG);
            if (gnt_any) begin
                wreg_q  <= gnt_reg;
                wdata_q <= gnt_data;
            end
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_reg    = wreg_q;
    assign rf_write_data   = wdata_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dump_start && cpu_halted) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                dump_valid = 1'b1;
                if (!cpu_halted)
                    state_d = IDLE;
                else if (dump_ready) begin
                    if (idx_q == 5'(NUM_GPR-1))
                        state_d = DONE;
                    else
                        idx_d = idx_q + 5'd1;
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign cpu_rd_stall  = (state_q == SCAN);
    assign dump_idx      = idx_q;
    assign rf_read_reg_1 = cpu_rd_stall ? idx_q : cpu_read_reg_1;
    assign rf_read_reg_2 = cpu_read_reg_2;

    // While scanning, port 1 carries dump_idx, so cpu_read_data_1 is meaningless (cpu_rd_stall is high).
    assign cpu_read_data_1 = fwd_read(we_q, wreg_q, wdata_q, cpu_read_reg_1, rf_read_data_1);
    assign cpu_read_data_2 = fwd_read(we_q, wreg_q, wdata_q, cpu_read_reg_2, rf_read_data_2);
    assign dump_data       = fwd_read(we_q, wreg_q, wdata_q, idx_q, rf_read_data_1);

endmodule

// File: tb/tb_mips_cpu_regfile_port_ctrl.sv
// Bench for mips_cpu_regfile_port_ctrl: regfile model, write-stage scoreboard and dump checks.
module tb_mips_cpu_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg, rf_read_reg_1, rf_read_reg_2;
    logic [31:0] rf_write_data, rf_read_data_1, rf_read_data_2;
    logic [4:0]  cpu_read_reg_1, cpu_read_reg_2;
    logic [31:0] cpu_read_data_1, cpu_read_data_2;
    logic        cpu_halted, cpu_rd_stall, dump_start, dump_valid, dump_ready, dump_done;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    // Fixed-priority instance: only its grant is observed.
    logic [2:0]  fx_ready;
    logic        fx_we, fx_stall, fx_dvalid, fx_ddone;
    logic [4:0]  fx_wreg, fx_rreg1, fx_rreg2, fx_didx;
    logic [31:0] fx_wdata, fx_cdata1, fx_cdata2, fx_ddata;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;
    wr_t wq[$];

    int          m_ptr;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    mips_cpu_regfile_port_ctrl #(.NREQ(3), .RR_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .cpu_read_reg_1(cpu_read_reg_1), .cpu_read_reg_2(cpu_read_reg_2),
        .cpu_read_data_1(cpu_read_data_1), .cpu_read_data_2(cpu_read_data_2),
        .cpu_halted(cpu_halted), .cpu_rd_stall(cpu_rd_stall),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
    );

    mips_cpu_regfile_port_ctrl #(.NREQ(3), .RR_EN(0)) dut_fx (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(fx_ready),
        .rf_write_enable(fx_we), .rf_write_reg(fx_wreg), .rf_write_data(fx_wdata),
        .rf_read_reg_1(fx_rreg1), .rf_read_reg_2(fx_rreg2),
        .rf_read_data_1(32'd0), .rf_read_data_2(32'd0),
        .cpu_read_reg_1(cpu_read_reg_1), .cpu_read_reg_2(cpu_read_reg_2),
        .cpu_read_data_1(fx_cdata1), .cpu_read_data_2(fx_cdata2),
        .cpu_halted(1'b0), .cpu_rd_stall(fx_stall),
        .dump_start(1'b0), .dump_valid(fx_dvalid), .dump_ready(1'b0),
        .dump_idx(fx_didx), .dump_data(fx_ddata), .dump_done(fx_ddone)
    );

    // Register file model: combinational read, write on the clock edge, $0 hardwired to zero.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_write_enable) begin
            regs[rf_write_reg] <= rf_write_data;
        end
    end
    assign rf_read_data_1 = (rf_read_reg_1 == 5'd0) ? 32'd0 : regs[rf_read_reg_1];
    assign rf_read_data_2 = (rf_read_reg_2 == 5'd0) ? 32'd0 : regs[rf_read_reg_2];

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_reg[5*i +: 5]   = r;
        req_data[32*i +: 32] = d;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_reg  = 5'd0;
        m_data = 32'd0;
        wq.delete();
    endtask

    // One clock: check grants, push the expected write stage, then pop and compare after the edge.
    task automatic cycle();
        logic [2:0] eg;
        logic [2:0] efx;
        wr_t        e;
        int         g;
        #1;
        eg = 3'b000;
        g  = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        end
        if (g >= 0) eg[g] = 1'b1;
        checks++;
        if (req_ready !== eg) begin
            errors++;
            $display("FAIL rr_grant: got %b expected %b", req_ready, eg);
        end
        efx = req_valid & (~req_valid + 3'd1);
        checks++;
        if (fx_ready !== efx) begin
            errors++;
            $display("FAIL fixed_grant: got %b expected %b", fx_ready, efx);
        end
        if (g >= 0) begin
            m_reg  = req_reg[5*g +: 5];
            m_data = req_data[32*g +: 32];
            m_ptr  = (g + 1) % 3;
            wq.push_back('{we: (m_reg != 5'd0), r: m_reg, d: m_data});
        end else begin
            wq.push_back('{we: 1'b0, r: m_reg, d: m_data});
        end
        @(negedge clk);
        checks++;
        if (wq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = wq.pop_front();
            if ({rf_write_enable, rf_write_reg, rf_write_data} !== {e.we, e.r, e.d}) begin
                errors++;
                $display("FAIL write_stage: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
                         rf_write_enable, rf_write_reg, rf_write_data, e.we, e.r, e.d);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({rf_write_enable, rf_write_reg, rf_write_data, dump_valid, dump_done, dump_idx, cpu_rd_stall} !== '0) begin
            errors++;
            $display("FAIL %s: got we=%b reg=%0d data=%h valid=%b done=%b idx=%0d stall=%b expected all zero",
                     tag, rf_write_enable, rf_write_reg, rf_write_data, dump_valid, dump_done, dump_idx, cpu_rd_stall);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_reg = '0; req_data = '0;
        cpu_read_reg_1 = '0; cpu_read_reg_2 = '0;
        cpu_halted = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_seq [6] = '{5'd8, 5'd9, 5'd10, 5'd8, 5'd9, 5'd10};
        set_req(0, 5'd8,  32'hA000_0008);
        set_req(1, 5'd9,  32'hB000_0009);
        set_req(2, 5'd10, 32'hC000_000A);
        req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            cycle();
            checks++;
            if (rf_write_reg !== exp_seq[n]) begin
                errors++;
                $display("FAIL rr_sequence[%0d]: got %0d expected %0d", n, rf_write_reg, exp_seq[n]);
            end
        end
        req_valid = 3'b000;
        cycle();
    endtask

    task automatic test_forwarding();
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        cpu_read_reg_1 = 5'd5;
        cycle();
        req_valid = 3'b000;
        #1;
        checks++;
        if (cpu_read_data_1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fwd_read1: got %h expected deadbeef", cpu_read_data_1);
        end
        cycle();
        cycle();
        cpu_read_reg_2 = 5'd5;
        #1;
        checks++;
        if ({cpu_read_data_1, cpu_read_data_2} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rf_read_after_commit: got %h/%h expected deadbeef/deadbeef", cpu_read_data_1, cpu_read_data_2);
        end
    endtask

    task automatic test_zero_reg();
        set_req(0, 5'd0, 32'h0000_1234);
        req_valid = 3'b001;
        cpu_read_reg_1 = 5'd0;
        cycle();
        req_valid = 3'b000;
        #1;
        checks++;
        if (cpu_read_data_1 !== 32'd0) begin
            errors++;
            $display("FAIL zero_read: got %h expected 0", cpu_read_data_1);
        end
        cycle();
    endtask

    task automatic test_dump_full();
        for (int i = 1; i < 32; i++) begin
            set_req(0, 5'(i), 32'(i * 3));
            req_valid = 3'b001;
            cycle();
        end
        req_valid = 3'b000;
        cycle();
        cpu_halted = 1'b1;
        dump_start = 1'b1;
        dump_ready = 1'b1;
        #1;
        checks++;
        if (cpu_rd_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_before_dump: got %b expected 0", cpu_rd_stall);
        end
        cycle();
        dump_start = 1'b0;
        for (int e = 0; e < 32; e++) begin
            #1;
            checks++;
            if ({dump_valid, cpu_rd_stall, dump_done, dump_idx, dump_data} !== {1'b1, 1'b1, 1'b0, 5'(e), 32'(e * 3)}) begin
                errors++;
                $display("FAIL dump_beat[%0d]: got v=%b stall=%b done=%b idx=%0d data=%0d expected v=1 stall=1 done=0 idx=%0d data=%0d",
                         e, dump_valid, cpu_rd_stall, dump_done, dump_idx, dump_data, e, e * 3);
            end
            cycle();
        end
        checks++;
        if ({dump_done, dump_valid, cpu_rd_stall} !== 3'b100) begin
            errors++;
            $display("FAIL dump_done_pulse: got done=%b valid=%b stall=%b expected 1/0/0", dump_done, dump_valid, cpu_rd_stall);
        end
        cycle();
        checks++;
        if (dump_done !== 1'b0) begin
            errors++;
            $display("FAIL dump_done_single: got %b expected 0", dump_done);
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_dump_stall_abort();
        int e = 0;
        int n = 0;
        dump_start = 1'b1;
        dump_ready = 1'b0;
        cycle();
        dump_start = 1'b0;
        while (e < 17 && n < 80) begin
            dump_ready = n[0];
            #1;
            checks++;
            if ({dump_valid, dump_idx, dump_data} !== {1'b1, 5'(e), 32'(e * 3)}) begin
                errors++;
                $display("FAIL toggle_beat[%0d]: got v=%b idx=%0d data=%0d expected v=1 idx=%0d data=%0d",
                         n, dump_valid, dump_idx, dump_data, e, e * 3);
            end
            cycle();
            if (dump_ready) e++;
            n++;
        end
        if (e < 17) begin
            errors++;
            $display("FAIL toggle_budget: got idx %0d expected 17 within 80 cycles", e);
        end
        dump_ready = 1'b0;
        cpu_halted = 1'b0;
        #1;
        checks++;
        if (dump_idx !== 5'd17) begin
            errors++;
            $display("FAIL abort_idx: got %0d expected 17", dump_idx);
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({dump_valid, cpu_rd_stall, dump_done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_idle[%0d]: got valid=%b stall=%b done=%b expected 0/0/0", k, dump_valid, cpu_rd_stall, dump_done);
            end
            cycle();
        end
    endtask

    task automatic test_fixed_priority();
        req_valid = 3'b111;
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (fx_ready !== 3'b001) begin
                errors++;
                $display("FAIL fixed_all_valid[%0d]: got %b expected 001", n, fx_ready);
            end
            cycle();
        end
        req_valid = 3'b000;
        cycle();
    endtask

    task automatic test_reset_mid_dump();
        set_req(0, 5'd8,  32'd24);
        set_req(1, 5'd9,  32'd27);
        set_req(2, 5'd10, 32'd30);
        cpu_halted = 1'b1;
        dump_start = 1'b1;
        cycle();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        req_valid  = 3'b111;
        for (int e = 0; e < 5; e++) begin
            #1;
            checks++;
            if ({dump_idx, dump_data} !== {5'(e), 32'(e * 3)}) begin
                errors++;
                $display("FAIL pre_reset_beat[%0d]: got idx=%0d data=%0d expected idx=%0d data=%0d", e, dump_idx, dump_data, e, e * 3);
            end
            cycle();
        end
        reset = 1'b1;
        req_valid = 3'b000;
        @(negedge clk);
        check_reset_outputs("reset_mid_dump");
        reset = 1'b0;
        model_reset();
        cycle();
        checks++;
        if ({dump_done, dump_valid} !== 2'b00) begin
            errors++;
            $display("FAIL no_done_after_reset: got done=%b valid=%b expected 0/0", dump_done, dump_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_forwarding();
        test_zero_reg();
        test_dump_full();
        test_dump_stall_abort();
        test_fixed_priority();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
